// File: rtl/serial_adder_mux.sv
// Digit-serial adder/subtractor built from 2:1-mux full-adder cells.
// Processes DIGIT bits per clock, LSB digit first, start/done handshake.
module mux2_1 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

module serial_adder_mux #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_adder_mux: WIDTH must be >=2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;
  logic accept, last;

  logic [WIDTH-1:0] a_q, b_q, res_q, res_nx;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] ds;
  logic             dig_co, msb_ci;

  // Ripple of mux full-adder cells over one digit.
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    logic ci, p, s, co;
    if (i == 0) begin : g_c0
      assign ci = carry_q;
    end else begin : g_cn
      assign ci = g_cell[i-1].co;
    end
    mux2_1 u_p (.d0(b_q[i]), .d1(~b_q[i]), .sel(a_q[i]), .y(p));
    mux2_1 u_s (.d0(ci),     .d1(~ci),     .sel(p),      .y(s));
    mux2_1 u_c (.d0(a_q[i]), .d1(ci),      .sel(p),      .y(co));
    assign ds[i] = s;
  end

  assign dig_co = g_cell[DIGIT-1].co;
  assign msb_ci = g_cell[DIGIT-1].ci;

  // Digit sum enters the result register from the MSB end.
  if (DIGIT == WIDTH) begin : g_full
    assign res_nx = ds;
  end else begin : g_shift
    assign res_nx = {ds, res_q[WIDTH-1:DIGIT]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, handshake outputs and datapath strobes.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    last     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, digit shifting and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= op_sub ? ~b : b;
      carry_q <= op_sub ? 1'b1 : cin;
      cnt     <= '0;
    end else if (busy) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      res_q   <= res_nx;
      carry_q <= dig_co;
      cnt     <= cnt + 1'b1;
      if (last) begin
        sum      <= res_nx;
        cout     <= dig_co;
        overflow <= dig_co ^ msb_ci;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_mux.sv
// Bench for serial_adder_mux: directed + random 8-bit ops,
// exhaustive 4-bit ops for DIGIT 1, 2 and 4.
module tb_serial_adder_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, op_sub, cin;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  logic       start4, sub4, cin4;
  logic [3:0] a4, b4;
  logic [2:0] busy4, done4, cout4, ovf4;
  logic [3:0] sum4 [3];

  int errors = 0;
  int checks = 0;

  serial_adder_mux #(.WIDTH(8), .DIGIT(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub),
    .a(a), .b(b), .cin(cin), .busy(busy), .done(done),
    .sum(sum), .cout(cout), .overflow(ovf)
  );

  serial_adder_mux #(.WIDTH(4), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start4), .op_sub(sub4),
    .a(a4), .b(b4), .cin(cin4), .busy(busy4[0]), .done(done4[0]),
    .sum(sum4[0]), .cout(cout4[0]), .overflow(ovf4[0])
  );

  serial_adder_mux #(.WIDTH(4), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start4), .op_sub(sub4),
    .a(a4), .b(b4), .cin(cin4), .busy(busy4[1]), .done(done4[1]),
    .sum(sum4[1]), .cout(cout4[1]), .overflow(ovf4[1])
  );

  serial_adder_mux #(.WIDTH(4), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start4), .op_sub(sub4),
    .a(a4), .b(b4), .cin(cin4), .busy(busy4[2]), .done(done4[2]),
    .sum(sum4[2]), .cout(cout4[2]), .overflow(ovf4[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Integer reference: returns {ovf, cout, sum}.
  function automatic logic [31:0] ref_op(int w, int x, int y,
                                         int ci, int sub);
    int mask, half, sx, sy, r, sr, c, v;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    sx = (x >= half) ? x - (1 << w) : x;
    sy = (y >= half) ? y - (1 << w) : y;
    if (sub != 0) begin
      r  = x - y;
      c  = (x >= y) ? 1 : 0;
      sr = sx - sy;
    end else begin
      r  = x + y + ci;
      c  = r >> w;
      sr = sx + sy + ci;
    end
    v = (sr < -half || sr >= half) ? 1 : 0;
    return 32'((v << (w + 1)) | (c << w) | (r & mask));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input logic sub);
    a = x; b = y; cin = ci; op_sub = sub; start = 1'b1;
    tick();
    start  = 1'b0;
    a      = 8'($urandom);
    b      = 8'($urandom);
    cin    = 1'($urandom);
    op_sub = 1'($urandom);
  endtask

  task automatic wait8(input string tag, input logic [7:0] x,
                       input logic [7:0] y, input logic ci,
                       input logic sub, input int lat);
    int n;
    logic [31:0] e;
    logic [7:0] held;
    e = ref_op(8, int'(x), int'(y), int'(ci), int'(sub));
    held = sum;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
      if (!done) chk({tag, " hold"}, 32'(sum), 32'(held));
    end
    chk({tag, " lat"}, 32'(n), 32'(lat));
    chk({tag, " sum"}, 32'(sum), 32'(e[7:0]));
    chk({tag, " cout"}, 32'(cout), 32'(e[8]));
    chk({tag, " ovf"}, 32'(ovf), 32'(e[9]));
    chk({tag, " nbusy"}, 32'(busy), 32'd0);
  endtask

  task automatic op4(input int x, input int y, input int ci, input int sub);
    int lat [3];
    int exp_lat [3];
    logic [31:0] e;
    exp_lat = '{4, 2, 1};
    lat = '{0, 0, 0};
    a4 = 4'(x); b4 = 4'(y); cin4 = 1'(ci); sub4 = 1'(sub);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      tick();
      for (int k = 0; k < 3; k++)
        if (done4[k] && lat[k] == 0) lat[k] = n;
    end
    e = ref_op(4, x, y, ci, sub);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("w4[%0d] %h%s%h+%0d lat", k, x, sub ? "-" : "+", y, ci),
          32'(lat[k]), 32'(exp_lat[k]));
      chk($sformatf("w4[%0d] %h/%h sum", k, x, y), 32'(sum4[k]), 32'(e[3:0]));
      chk($sformatf("w4[%0d] %h/%h cout", k, x, y), 32'(cout4[k]), 32'(e[4]));
      chk($sformatf("w4[%0d] %h/%h ovf", k, x, y), 32'(ovf4[k]), 32'(e[5]));
    end
  endtask

  initial begin
    int cnt_done;
    logic [7:0] rx, ry;
    logic rc, rs;

    rst = 1'b1; start = 1'b0; op_sub = 1'b0; cin = 1'b0;
    a = '0; b = '0;
    start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst sum", 32'(sum), 32'd0);
    chk("rst cout", 32'(cout), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);

    start8(8'hFF, 8'h01, 1'b0, 1'b0);
    wait8("ff+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8);
    tick();
    start8(8'h7F, 8'h01, 1'b0, 1'b0);
    wait8("7f+01", 8'h7F, 8'h01, 1'b0, 1'b0, 8);
    tick();
    start8(8'h80, 8'h80, 1'b0, 1'b0);
    wait8("80+80", 8'h80, 8'h80, 1'b0, 1'b0, 8);
    tick();
    start8(8'h05, 8'h07, 1'b1, 1'b1);
    wait8("05-07", 8'h05, 8'h07, 1'b1, 1'b1, 8);
    tick();
    start8(8'h80, 8'h01, 1'b0, 1'b1);
    wait8("80-01", 8'h80, 8'h01, 1'b0, 1'b1, 8);
    tick();

    start8(8'h11, 8'h22, 1'b0, 1'b0);
    tick();
    tick();
    a = 8'hAA; b = 8'hBB; start = 1'b1;
    tick();
    start = 1'b0;
    wait8("ignore", 8'h11, 8'h22, 1'b0, 1'b0, 5);
    start8(8'h33, 8'h44, 1'b1, 1'b0);
    wait8("b2b", 8'h33, 8'h44, 1'b1, 1'b0, 8);
    tick();

    start8(8'h5A, 8'h3C, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort sum", 32'(sum), 32'd0);
    cnt_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) cnt_done++;
      tick();
    end
    chk("abort nodone", 32'(cnt_done), 32'd0);
    start8(8'h12, 8'h34, 1'b1, 1'b0);
    wait8("post-rst", 8'h12, 8'h34, 1'b1, 1'b0, 8);
    tick();

    for (int i = 0; i < 40; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      start8(rx, ry, rc, rs);
      wait8($sformatf("rnd%0d", i), rx, ry, rc, rs, 8);
      if ($urandom_range(1) == 0) tick();
    end
    tick();

    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++)
            op4(x, y, c, s);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
